timer_core: RTL and testbench

Programmable down-counting timer built around the team's clocked storage stage. It sits directly downstream of the flip-flop/clock-enable stage and consumes synchronized start/stop controls. It generates a prescaled decrement strobe, counts a loaded value to zero, and raises a one-cycle expiry tick plus a sticky interrupt. It supports one-shot and periodic (auto-reload) modes.

---
 rtl/timer_pkg.sv | 9 +
 rtl/timer_core_if.sv | 30 +++
 rtl/timer_prescaler.sv | 40 ++++
 rtl/timer_core.sv | 102 ++++++++++
 tb/tb_timer_core.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and default widths for the programmable down-counting timer.
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned PRE_W_DEF = 8;

    typedef enum logic [0:0] {T_IDLE, T_RUN} timer_state_e;

endpackage

// File: rtl/timer_core_if.sv
// Control/status bundle between a timer user (master) and timer_core (slave).
interface timer_core_if
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
);

    logic             start;
    logic             stop;
    logic             periodic;
    logic [PRE_W-1:0] pre_div;
    logic [CNT_W-1:0] load_val;
    logic             irq_ack;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             irq;
    logic             busy;

    modport master (
        output start, stop, periodic, pre_div, load_val, irq_ack,
        input  count, tick, irq, busy
    );

    modport slave (
        input  start, stop, periodic, pre_div, load_val, irq_ack,
        output count, tick, irq, busy
    );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: emits ce once every shadow_p+1 enabled cycles; restart reloads the divider.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] shadow_p,
    output logic             ce
);

    logic [PRE_W-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        ce    = 1'b0;
        if (restart) begin
            pre_d = shadow_p;
        end else if (en) begin
            if (pre_q == '0) begin
                ce    = 1'b1;
                pre_d = shadow_p;
            end else begin
                pre_d = pre_q - PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/timer_core.sv
// Down-counting timer: FSM, counter, shadow registers, registered expiry tick and sticky irq.
module timer_core
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic         clk,
    input  logic         clr,
    timer_core_if.slave  bus
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shadow_l_q, shadow_l_d;
    logic [PRE_W-1:0] shadow_p_q, shadow_p_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             tick_q, tick_d;
    logic             irq_q, irq_d;
    logic             accept_start;
    logic             expire;
    logic             ce;
    logic             busy;
    logic [PRE_W-1:0] pre_src;

    assign busy         = (state_q == T_RUN);
    assign accept_start = bus.start && !bus.stop && (bus.load_val != '0);
    // On a start the divider must see the incoming value, not the stale shadow.
    assign pre_src      = accept_start ? bus.pre_div : shadow_p_q;

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .clr      (clr),
        .en       (busy),
        .restart  (accept_start),
        .shadow_p (pre_src),
        .ce       (ce)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        shadow_l_d    = shadow_l_q;
        shadow_p_d    = shadow_p_q;
        shadow_mode_d = shadow_mode_q;
        expire        = 1'b0;

        // Priority: stop, then (re)start, then the normal countdown.
        if (busy && bus.stop) begin
            state_d = T_IDLE;
        end else if (accept_start) begin
            state_d       = T_RUN;
            count_d       = bus.load_val;
            shadow_l_d    = bus.load_val;
            shadow_p_d    = bus.pre_div;
            shadow_mode_d = bus.periodic;
        end else if (busy && ce) begin
            if (count_q > CNT_W'(1)) begin
                count_d = count_q - CNT_W'(1);
            end else if (count_q == CNT_W'(1)) begin
                expire = 1'b1;
                if (shadow_mode_q) begin
                    count_d = shadow_l_q;
                end else begin
                    count_d = '0;
                    state_d = T_IDLE;
                end
            end
        end

        tick_d = expire;
        irq_d  = expire | (irq_q & ~bus.irq_ack);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= T_IDLE;
            count_q       <= '0;
            shadow_l_q    <= '0;
            shadow_p_q    <= '0;
            shadow_mode_q <= 1'b0;
            tick_q        <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shadow_l_q    <= shadow_l_d;
            shadow_p_q    <= shadow_p_d;
            shadow_mode_q <= shadow_mode_d;
            tick_q        <= tick_d;
            irq_q         <= irq_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.irq   = irq_q;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: one-shot, periodic, stop, sticky irq, async clear, restart.
module tb_timer_core;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PRE_W = 8;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    timer_core_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

    timer_core #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] l, input logic [PRE_W-1:0] p,
                            input logic per);
        bus.start    = 1'b1;
        bus.load_val = l;
        bus.pre_div  = p;
        bus.periodic = per;
        step();
        bus.start    = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        clr          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.periodic = 1'b0;
        bus.pre_div  = '0;
        bus.load_val = '0;
        bus.irq_ack  = 1'b0;

        #12;
        check_eq("rst_count", 32'(bus.count), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_tick", 32'(bus.tick), 0);
        check_eq("rst_irq", 32'(bus.irq), 0);
        clr = 1'b0;

        // 1: one-shot L=3 P=0
        do_start(16'd3, 8'd0, 1'b0);
        check_eq("t1_e0_count", 32'(bus.count), 3);
        check_eq("t1_e0_busy", 32'(bus.busy), 1);
        step();
        check_eq("t1_e1_count", 32'(bus.count), 2);
        step();
        check_eq("t1_e2_count", 32'(bus.count), 1);
        check_eq("t1_e2_tick", 32'(bus.tick), 0);
        step();
        check_eq("t1_e3_count", 32'(bus.count), 0);
        check_eq("t1_e3_tick", 32'(bus.tick), 1);
        check_eq("t1_e3_irq", 32'(bus.irq), 1);
        check_eq("t1_e3_busy", 32'(bus.busy), 0);
        step();
        check_eq("t1_e4_tick", 32'(bus.tick), 0);
        check_eq("t1_e4_irq", 32'(bus.irq), 1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        check_eq("t1_ack_irq", 32'(bus.irq), 0);

        // 2: periodic L=2 P=2, expiry every 6 edges
        do_start(16'd2, 8'd2, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            step();
            check_eq("t2_tick", 32'(bus.tick), (k % 6 == 0) ? 1 : 0);
            check_eq("t2_count", 32'(bus.count), (k % 6 < 3) ? 2 : 1);
        end
        check_eq("t2_busy", 32'(bus.busy), 1);
        check_eq("t2_irq", 32'(bus.irq), 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check_eq("t2_stop_busy", 32'(bus.busy), 0);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        check_eq("t2_ack_irq", 32'(bus.irq), 0);

        // 3: stop at E4 holds count 7
        do_start(16'd10, 8'd0, 1'b0);
        step();
        step();
        step();
        check_eq("t3_e3_count", 32'(bus.count), 7);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check_eq("t3_stop_count", 32'(bus.count), 7);
        check_eq("t3_stop_busy", 32'(bus.busy), 0);
        check_eq("t3_stop_tick", 32'(bus.tick), 0);
        check_eq("t3_stop_irq", 32'(bus.irq), 0);
        step();
        check_eq("t3_hold_count", 32'(bus.count), 7);

        // 6a: start with load_val=0 is ignored
        do_start(16'd0, 8'd0, 1'b0);
        check_eq("t6_zero_busy", 32'(bus.busy), 0);
        check_eq("t6_zero_count", 32'(bus.count), 7);

        // 3 cont. / 4: start L=5, ack coincident with expiry at E5
        do_start(16'd5, 8'd0, 1'b0);
        check_eq("t3_reload_count", 32'(bus.count), 5);
        step();
        step();
        step();
        check_eq("t4_e3_count", 32'(bus.count), 2);
        bus.irq_ack = 1'b1;
        step();
        check_eq("t4_e4_irq", 32'(bus.irq), 0);
        step();
        check_eq("t4_e5_tick", 32'(bus.tick), 1);
        check_eq("t4_e5_irq_set_wins", 32'(bus.irq), 1);
        step();
        bus.irq_ack = 1'b0;
        check_eq("t4_ack_irq", 32'(bus.irq), 0);
        check_eq("t4_ack_tick", 32'(bus.tick), 0);

        // 5: async clear right after a periodic expiry
        do_start(16'd5, 8'd0, 1'b1);
        for (int k = 1; k <= 5; k++) step();
        check_eq("t5_pre_tick", 32'(bus.tick), 1);
        check_eq("t5_pre_count", 32'(bus.count), 5);
        #2;
        clr = 1'b1;
        #1;
        check_eq("t5_clr_count", 32'(bus.count), 0);
        check_eq("t5_clr_busy", 32'(bus.busy), 0);
        check_eq("t5_clr_irq", 32'(bus.irq), 0);
        check_eq("t5_clr_tick", 32'(bus.tick), 0);
        #1;
        clr = 1'b0;
        do_start(16'd1, 8'd0, 1'b0);
        check_eq("t5_l1_count", 32'(bus.count), 1);
        step();
        check_eq("t5_l1_tick", 32'(bus.tick), 1);
        check_eq("t5_l1_busy", 32'(bus.busy), 0);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;

        // 6b: restart at count=1 suppresses the expiry
        do_start(16'd2, 8'd0, 1'b0);
        step();
        check_eq("t6_pre_count", 32'(bus.count), 1);
        do_start(16'd4, 8'd0, 1'b0);
        check_eq("t6_restart_count", 32'(bus.count), 4);
        check_eq("t6_restart_tick", 32'(bus.tick), 0);
        check_eq("t6_restart_irq", 32'(bus.irq), 0);
        step();
        check_eq("t6_next_count", 32'(bus.count), 3);
        check_eq("t6_next_tick", 32'(bus.tick), 0);

        // stop beats a coincident start
        bus.stop = 1'b1;
        do_start(16'd9, 8'd0, 1'b0);
        bus.stop = 1'b0;
        check_eq("stop_vs_start_busy", 32'(bus.busy), 0);
        check_eq("stop_vs_start_count", 32'(bus.count), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
